// File: rtl/dvr_pkg.sv
// Shared types for the dvr_if width converters.
package dvr_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} dvr_width_down_state_e;
endpackage

// File: rtl/dvr_width_down.sv
// Width down-converter: one RATIO*DATA_WIDTH word in, RATIO DATA_WIDTH beats out.
// Zero-bubble between words: the next word is taken on the last beat's transfer.
module dvr_width_down
  import dvr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [RATIO*DATA_WIDTH-1:0]   wide_data,
  input  logic                          wide_vld,
  output logic                          wide_rdy,
  output logic [DATA_WIDTH-1:0]         narrow_data,
  output logic                          narrow_vld,
  input  logic                          narrow_rdy,
  output logic [$clog2(RATIO)-1:0]      beat_idx,
  output logic                          busy
);
  localparam int IDX_W = $clog2(RATIO);
  typedef logic [IDX_W-1:0] beat_idx_t;
  localparam beat_idx_t LAST = beat_idx_t'(RATIO - 1);

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("dvr_width_down: RATIO must be >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("dvr_width_down: DATA_WIDTH must be >= 1");
    end
  endgenerate

  dvr_width_down_state_e                 state_q, state_d;
  logic [RATIO-1:0][DATA_WIDTH-1:0]      hold_q;
  beat_idx_t                             idx_q, sel;
  logic                                  last, narrow_fire, wide_fire;

  assign last        = (idx_q == LAST);
  assign narrow_vld  = (state_q == SEND);
  assign busy        = (state_q == SEND);
  assign beat_idx    = idx_q;
  // Only combinational ready path: refill on the last beat's handshake.
  assign wide_rdy    = rst_n & ((state_q == IDLE) | ((state_q == SEND) & last & narrow_rdy));
  assign narrow_fire = narrow_vld & narrow_rdy;
  assign wide_fire   = wide_vld & wide_rdy;
  assign sel         = MSB_FIRST ? beat_idx_t'(LAST - idx_q) : idx_q;
  assign narrow_data = hold_q[sel];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (wide_fire) state_d = SEND;
      SEND: if (narrow_fire && last && !wide_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wide_fire) begin
        hold_q <= wide_data;
        idx_q  <= '0;
      end else if (narrow_fire) begin
        idx_q <= last ? '0 : beat_idx_t'(idx_q + 1'b1);
      end
    end
  end
endmodule
